// File: rtl/uop_sequencer.sv
//------------------------------------------------------------------------------
// uop_sequencer: two-byte instruction fetch plus micro-op step sequencer.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uop_sequencer #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                             CLK,
  input  logic                             N_RST,
  input  logic                             N_BOOTED,
  input  logic [7:0]                       INSTR_DATA,
  input  logic                             INSTR_VALID,
  output logic                             INSTR_READY,
  input  logic                             UOP_DONE,
  input  logic                             STALL,
  output logic [OPCODE_WIDTH-1:0]          OPCODE,
  output logic [3:0]                       REG0_IDX,
  output logic [3:0]                       REG1_IDX,
  output logic [STEP_WIDTH-1:0]            STEP,
  output logic [OPCODE_WIDTH+STEP_WIDTH-1:0] UOP_ADDR,
  output logic                             N_UOP_VALID,
  output logic                             FAULT
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [STEP_WIDTH-1:0] c_STEP_MAX = {STEP_WIDTH{1'b1}};

  state_t                    r_state, w_state_nxt;
  logic [OPCODE_WIDTH-1:0]   r_pend,  w_pend_nxt;
  logic [OPCODE_WIDTH-1:0]   r_op,    w_op_nxt;
  logic [3:0]                r_reg0,  w_reg0_nxt;
  logic [3:0]                r_reg1,  w_reg1_nxt;
  logic [STEP_WIDTH-1:0]     r_step,  w_step_nxt;
  logic                      r_fault, w_fault_nxt;
  logic                      w_ready;

  assign w_ready = (r_state == S_FETCH0) || (r_state == S_FETCH1);

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_state <= S_BOOT;
      r_pend  <= '0;
      r_op    <= '0;
      r_reg0  <= '0;
      r_reg1  <= '0;
      r_step  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_op    <= w_op_nxt;
      r_reg0  <= w_reg0_nxt;
      r_reg1  <= w_reg1_nxt;
      r_step  <= w_step_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_op_nxt    = r_op;
    w_reg0_nxt  = r_reg0;
    w_reg1_nxt  = r_reg1;
    w_step_nxt  = r_step;
    w_fault_nxt = r_fault;

    // Re-entering bootstrap discards any partial or running instruction; a trap survives it.
    if (N_BOOTED && (r_state != S_HALT)) begin
      w_state_nxt = S_BOOT;
      w_pend_nxt  = '0;
      w_op_nxt    = '0;
      w_reg0_nxt  = '0;
      w_reg1_nxt  = '0;
      w_step_nxt  = '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          w_state_nxt = S_FETCH0;
        end
        S_FETCH0: begin
          if (INSTR_VALID && w_ready) begin
            w_pend_nxt  = INSTR_DATA[OPCODE_WIDTH-1:0];
            w_state_nxt = S_FETCH1;
          end
        end
        S_FETCH1: begin
          // All instruction fields update on the same edge so control never sees a mix.
          if (INSTR_VALID && w_ready) begin
            w_op_nxt    = r_pend;
            w_reg0_nxt  = INSTR_DATA[3:0];
            w_reg1_nxt  = INSTR_DATA[7:4];
            w_step_nxt  = '0;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (STALL) begin
            w_state_nxt = S_EXEC;
          end else if (UOP_DONE) begin
            w_step_nxt  = '0;
            w_state_nxt = S_FETCH0;
          end else if (r_step == c_STEP_MAX) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_step_nxt  = r_step + STEP_WIDTH'(1);
          end
        end
        S_HALT: begin
          w_state_nxt = S_HALT;
        end
        default: begin
          w_state_nxt = S_BOOT;
        end
      endcase
    end
  end

  assign INSTR_READY = w_ready;
  assign N_UOP_VALID = (r_state != S_EXEC);
  assign FAULT       = r_fault;
  assign OPCODE      = r_op;
  assign REG0_IDX    = r_reg0;
  assign REG1_IDX    = r_reg1;
  assign STEP        = r_step;
  assign UOP_ADDR    = {r_op, r_step};

endmodule

`default_nettype wire

// File: doc/uop_sequencer.md
# uop_sequencer

Instruction sequencer directly upstream of the control logic. It fetches each two-byte instruction over a valid/ready byte stream and latches the opcode and register fields atomically. It then steps a micro-op counter to form the microcode address `{OPCODE, STEP}` until microcode signals end-of-instruction. It holds idle while the machine is bootstrapping and traps on runaway micro-op sequences.

## Interface
- `OPCODE_WIDTH`, default 6: opcode field width. Drives microcode address high bits.
- `STEP_WIDTH`, default 3: micro-op step counter width. Maximum step is `2**STEP_WIDTH-1`.

Ports:
- `CLK` in 1: single clock. All state changes on the rising edge.
- `N_RST` in 1: reset, asynchronous and active-low.
- `N_BOOTED` in 1: 1 while bootstrapping (microcode not loaded); 0 once booted.
- `INSTR_DATA` in 8: instruction byte from instruction memory.
- `INSTR_VALID` in 1: `INSTR_DATA` holds a valid byte.
- `INSTR_READY` out 1: sequencer accepts a byte this cycle.
- `UOP_DONE` in 1: end-of-instruction bit from the current microcode word.
- `STALL` in 1: hold the current micro-op step (e.g. memory wait).
- `OPCODE` out `OPCODE_WIDTH`: latched opcode, fed to control logic.
- `REG0_IDX` out 4: latched register field 0.
- `REG1_IDX` out 4: latched register field 1.
- `STEP` out `STEP_WIDTH`: current micro-op step.
- `UOP_ADDR` out `OPCODE_WIDTH+STEP_WIDTH`: `{OPCODE, STEP}`.
- `N_UOP_VALID` out 1: active-low. 0 only in EXEC; gates the in/out plane decoders.
- `FAULT` out 1: sticky step-overflow trap.

## Operation
- Instruction format:
  - byte0[5:0] is the opcode; byte0[7:6] are reserved and ignored.
  - byte1 is `{REG1_IDX, REG0_IDX}`, with `REG0_IDX` = byte1[3:0].
- States:
  - BOOT: the fetch-and-execute state machine does not run.
  - FETCH0: waiting for byte0.
  - FETCH1: waiting for byte1.
  - EXEC: stepping micro-ops.
  - HALT: trapped.
- BOOT:
  - `INSTR_READY`=0, `N_UOP_VALID`=1, `STEP`=0.
  - Go to FETCH0 on the first edge with `N_BOOTED`=0.
- FETCH0:
  - `INSTR_READY`=1.
  - On an edge with VALID&READY (accept), capture byte0[5:0] into an internal pending register and go to FETCH1.
  - `OPCODE` is not changed here.
- FETCH1:
  - `INSTR_READY`=1.
  - On accept, load `OPCODE` from the pending register and `REG0_IDX`/`REG1_IDX` from byte1 in the same edge.
  - Set `STEP`=0 and go to EXEC.
  - The instruction fields therefore change atomically.
- EXEC:
  - `INSTR_READY`=0, `N_UOP_VALID`=0.
  - Per edge, in priority order:
    1. `STALL`=1: hold everything.
    2. `UOP_DONE`=1: `STEP`←0, go to FETCH0.
    3. `STEP`=max: go to HALT and set `FAULT`=1.
    4. Otherwise: `STEP`←`STEP`+1.
  - `STEP` never wraps.
- HALT:
  - `INSTR_READY`=0, `N_UOP_VALID`=1, `FAULT`=1.
  - `STEP` and the instruction fields are held.
  - Exit only via `N_RST`.
- `N_BOOTED` rising to 1 in any state other than HALT:
  - Go to BOOT on the next edge.
  - Clear `STEP`, `OPCODE`, `REG0_IDX`, `REG1_IDX` and the pending byte.
  - A partially fetched instruction is discarded.
- `UOP_ADDR` is purely combinational from the `OPCODE` and `STEP` registers.

## Timing
- Reset values (asynchronous, immediate on `N_RST`=0):
  - state = BOOT.
  - `OPCODE`=0, `REG0_IDX`=0, `REG1_IDX`=0, `STEP`=0, `UOP_ADDR`=0.
  - `INSTR_READY`=0, `N_UOP_VALID`=1, `FAULT`=0.
- Reset release takes effect at the first rising edge with `N_RST`=1.
- A byte is transferred only on an edge where `INSTR_VALID` and `INSTR_READY` are both 1.
  - `INSTR_READY` is a registered-state decode and does not depend on `INSTR_VALID`.
  - VALID may be asserted without waiting for READY.
- Latency:
  - Byte1 accept edge to `N_UOP_VALID`=0 with `STEP`=0: 0 cycles, visible immediately after that edge.
  - Minimum instruction time: 2 fetch cycles + (n+1) EXEC cycles, where n is the `STEP` value at which `UOP_DONE` is sampled.
  - Back-to-back instructions have no bubble beyond the fetch cycles.
- `UOP_DONE` and `STALL` are sampled only in EXEC; they are ignored elsewhere.
- `UOP_DONE` and `STALL` both 1: stall wins, and `UOP_DONE` is re-evaluated next edge.
- `UOP_DONE`=1 at `STEP`=max: instruction completes normally, no fault.
- All outputs are glitch-free registered values, except `UOP_ADDR`, which is a concatenation of registers only.

## Test plan
- Reset, then hold `N_BOOTED`=1 for 5 cycles:
  - all outputs at reset values and `INSTR_READY`=0 throughout.
- Drop `N_BOOTED` and stream bytes 0x2A, 0x53 with VALID held high:
  - `INSTR_READY`=1 for 2 cycles.
  - Then `OPCODE`=0x2A, `REG0_IDX`=3, `REG1_IDX`=5, `UOP_ADDR`=0x150.
  - `STEP` runs 0,1,2; `UOP_DONE` at step 2 returns to FETCH0.
- VALID low for 3 cycles between byte0 and byte1:
  - `OPCODE` keeps its old value until byte1 is accepted; no EXEC entry before that.
- `STALL`=1 at step 1 for 4 cycles, with `UOP_DONE` also high on the first stall cycle:
  - `STEP` stays at 1 for 4 cycles, then completion occurs on the first unstalled `UOP_DONE`.
- Never assert `UOP_DONE`:
  - `STEP` reaches 7, the next edge gives `FAULT`=1 and `N_UOP_VALID`=1.
  - `FAULT` holds until reset, even with `N_BOOTED` toggled.
- Raise `N_BOOTED` in FETCH1, and separately in EXEC at step 2:
  - BOOT on the next edge with the instruction fields cleared.
  - `N_RST` asserted mid-EXEC gives immediate reset values.
